// File: rtl/axis_prbs_checker.sv
// -----------------------------------------------------------------------------
// axis_prbs_checker
//
// Purpose:
//   Consumes an AXI-Stream of decrypted 32-bit words and regenerates the
//   PRBS-31 (x^31 + x^28 + 1) plaintext sequence. The checker locks itself to
//   the incoming stream, and it reports the following while locked:
//   - words compared
//   - bit errors
//   - lock-loss events
//
// Ports:
//   i_aclk         clock
//   i_aresetn      synchronous active-low reset
//   i_enable       1 = consume and check, 0 = tready low, state frozen
//   i_clear        one-cycle pulse that zeroes the three counters
//   s_axis_tready  registered copy of i_enable
//   s_axis_tvalid  input word valid
//   s_axis_tdata   input word, bit 31 is the earliest PRBS bit
//   o_locked       high while in LOCKED
//   o_state        0 = SEEK, 1 = CHECK, 2 = LOCKED
//   o_word_count   words compared while LOCKED (saturating)
//   o_bit_errors   mismatched bits accumulated while LOCKED (saturating)
//   o_lock_lost    LOCKED -> SEEK transitions (saturating)
// -----------------------------------------------------------------------------
module axis_prbs_checker #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_LOCK_COUNT   = 4,
  parameter int C_UNLOCK_COUNT = 3
) (
  input  logic                    i_aclk,
  input  logic                    i_aresetn,
  input  logic                    i_enable,
  input  logic                    i_clear,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tvalid,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  output logic                    o_locked,
  output logic [1:0]              o_state,
  output logic [31:0]             o_word_count,
  output logic [31:0]             o_bit_errors,
  output logic [7:0]              o_lock_lost
);

  typedef enum logic [1:0] {
    ST_SEEK   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int            CW         = 8;
  localparam logic [CW-1:0] LOCK_TGT   = CW'(C_LOCK_COUNT);
  localparam logic [CW-1:0] UNLOCK_TGT = CW'(C_UNLOCK_COUNT);

  // Advance the PRBS-31 state by one 32-bit word. The first generated bit
  // lands in bit 31. The new state is the low 31 bits of the result.
  function automatic logic [31:0] prbs_word(input logic [30:0] seed);
    logic [30:0] s;
    logic        b;
    logic [31:0] w;
    s = seed;
    w = 32'd0;
    for (int i = 0; i < 32; i++) begin
      b        = s[30] ^ s[27];
      w[31-i]  = b;
      s        = {s[29:0], b};
    end
    return w;
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  state_t        state_r;
  logic          tready_r;
  logic          locked_r;
  logic [30:0]   lfsr_r;
  logic [CW-1:0] match_cnt_r;
  logic [CW-1:0] err_cnt_r;
  logic [31:0]   word_count_r;
  logic [31:0]   bit_errors_r;
  logic [7:0]    lock_lost_r;

  logic          accept_s;
  logic [31:0]   data_s;
  logic [31:0]   expected_s;
  logic [31:0]   diff_s;
  logic          match_s;
  logic [5:0]    pop_s;
  logic [32:0]   be_sum_s;
  logic [31:0]   be_sat_s;
  logic [31:0]   wc_sat_s;
  logic [7:0]    ll_sat_s;

  // Prediction, comparison and saturating next values of the counters.
  always_comb begin
    accept_s   = s_axis_tvalid & tready_r;
    data_s     = s_axis_tdata;
    expected_s = prbs_word(lfsr_r);
    diff_s     = data_s ^ expected_s;
    match_s    = (diff_s == 32'd0);
    pop_s      = popcount32(diff_s);
    be_sum_s   = {1'b0, bit_errors_r} + {27'd0, pop_s};
    if (be_sum_s[32]) begin
      be_sat_s = 32'hFFFF_FFFF;
    end else begin
      be_sat_s = be_sum_s[31:0];
    end
    if (word_count_r == 32'hFFFF_FFFF) begin
      wc_sat_s = word_count_r;
    end else begin
      wc_sat_s = word_count_r + 32'd1;
    end
    if (lock_lost_r == 8'hFF) begin
      ll_sat_s = lock_lost_r;
    end else begin
      ll_sat_s = lock_lost_r + 8'd1;
    end
  end

  // Lock FSM, LFSR, counters and registered outputs.
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      state_r      <= ST_SEEK;
      tready_r     <= 1'b0;
      locked_r     <= 1'b0;
      lfsr_r       <= 31'd0;
      match_cnt_r  <= {CW{1'b0}};
      err_cnt_r    <= {CW{1'b0}};
      word_count_r <= 32'd0;
      bit_errors_r <= 32'd0;
      lock_lost_r  <= 8'd0;
    end else begin
      tready_r <= i_enable;
      if (accept_s) begin
        case (state_r)
          ST_SEEK: begin
            // An all-zero seed would lock the LFSR up, so it is ignored.
            if (data_s[30:0] != 31'd0) begin
              lfsr_r      <= data_s[30:0];
              match_cnt_r <= {CW{1'b0}};
              state_r     <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (match_s) begin
              lfsr_r      <= expected_s[30:0];
              match_cnt_r <= match_cnt_r + 8'd1;
              if (match_cnt_r + 8'd1 == LOCK_TGT) begin
                state_r   <= ST_LOCKED;
                locked_r  <= 1'b1;
                err_cnt_r <= {CW{1'b0}};
              end
            end else begin
              // The bad word is not reused as a seed. The next beat reseeds.
              state_r <= ST_SEEK;
            end
          end
          ST_LOCKED: begin
            // Once locked, the checker free-runs on its own prediction.
            lfsr_r       <= expected_s[30:0];
            word_count_r <= wc_sat_s;
            bit_errors_r <= be_sat_s;
            if (!match_s) begin
              if (err_cnt_r + 8'd1 == UNLOCK_TGT) begin
                state_r     <= ST_SEEK;
                locked_r    <= 1'b0;
                lock_lost_r <= ll_sat_s;
                err_cnt_r   <= {CW{1'b0}};
              end else begin
                err_cnt_r <= err_cnt_r + 8'd1;
              end
            end else begin
              err_cnt_r <= {CW{1'b0}};
            end
          end
          default: begin
            state_r  <= ST_SEEK;
            locked_r <= 1'b0;
          end
        endcase
      end
      // Clear overrides any increment made by a beat in the same cycle.
      if (i_clear) begin
        word_count_r <= 32'd0;
        bit_errors_r <= 32'd0;
        lock_lost_r  <= 8'd0;
      end
    end
  end

  assign s_axis_tready = tready_r;
  assign o_locked      = locked_r;
  assign o_state       = state_r;
  assign o_word_count  = word_count_r;
  assign o_bit_errors  = bit_errors_r;
  assign o_lock_lost   = lock_lost_r;

endmodule

// File: tb/tb_axis_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_prbs_checker
//
// Directed testbench for axis_prbs_checker. Expected PRBS words come from a
// sequence-recurrence reference model (x[n] = x[n-31] ^ x[n-28]).
// -----------------------------------------------------------------------------
module tb_axis_prbs_checker;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        clear;
  logic        tready;
  logic        tvalid;
  logic [31:0] tdata;
  logic        locked;
  logic [1:0]  state;
  logic [31:0] word_count;
  logic [31:0] bit_errors;
  logic [7:0]  lock_lost;

  int          tests = 0;
  int          fails = 0;
  logic [30:0] gs;
  logic [31:0] w;
  logic [31:0] want_wc;
  logic [31:0] want_be;
  logic [7:0]  want_ll;
  logic        prev_en;
  logic        v;
  logic        en;

  always #5 clk = ~clk;

  axis_prbs_checker dut (
    .i_aclk        (clk),
    .i_aresetn     (aresetn),
    .i_enable      (enable),
    .i_clear       (clear),
    .s_axis_tready (tready),
    .s_axis_tvalid (tvalid),
    .s_axis_tdata  (tdata),
    .o_locked      (locked),
    .o_state       (state),
    .o_word_count  (word_count),
    .o_bit_errors  (bit_errors),
    .o_lock_lost   (lock_lost)
  );

  // Reference PRBS: x[0..30] are the seed bits, oldest first.
  function automatic logic [31:0] gen_word(input logic [30:0] st);
    logic        x [0:62];
    logic [31:0] r;
    for (int i = 0; i < 31; i++) x[i] = st[30-i];
    for (int n = 31; n < 63; n++) x[n] = x[n-31] ^ x[n-28];
    r = 32'd0;
    for (int k = 0; k < 32; k++) r[31-k] = x[31+k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic beat(input logic [31:0] d);
    tvalid = 1'b1;
    tdata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic next_good(output logic [31:0] o);
    o  = gen_word(gs);
    gs = o[30:0];
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_wc"}, word_count, want_wc);
    chk({tag, "_be"}, bit_errors, want_be);
    chk({tag, "_ll"}, {24'd0, lock_lost}, {24'd0, want_ll});
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0; clear = 1'b0; tvalid = 1'b0; tdata = 32'd0;
    want_wc = 32'd0; want_be = 32'd0; want_ll = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", {31'd0, tready}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk_counters("rst");

    // 1: seed 7FFFFFFF, lock after beat 5, count 5 words by beat 10
    aresetn = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    chk("tready_on", {31'd0, tready}, 32'd1);
    beat(32'hFFFF_FFFF);
    gs = 31'h7FFF_FFFF;
    chk("t1_check", {30'd0, state}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      next_good(w);
      beat(w);
      if (i == 4) chk("t1_prelock", {31'd0, locked}, 32'd0);
    end
    chk("t1_locked", {31'd0, locked}, 32'd1);
    chk("t1_state", {30'd0, state}, 32'd2);
    for (int i = 6; i <= 10; i++) begin
      next_good(w);
      beat(w);
    end
    want_wc = 32'd5;
    chk_counters("t1");

    // 2: two flipped bits in one word
    next_good(w);
    beat(w ^ 32'h8000_0001);
    want_wc += 32'd1; want_be += 32'd2;
    chk_counters("t2");
    chk("t2_locked", {31'd0, locked}, 32'd1);
    next_good(w);
    beat(w);
    want_wc += 32'd1;

    // 3: three garbage words drop lock, then 1 + 4 words relock
    for (int i = 0; i < 3; i++) begin
      next_good(w);
      beat(32'hDEAD_BEEF);
      want_wc += 32'd1;
      want_be += 32'($countones(32'hDEAD_BEEF ^ w));
      if (i == 1) chk("t3_still", {30'd0, state}, 32'd2);
    end
    want_ll = 8'd1;
    chk("t3_seek", {30'd0, state}, 32'd0);
    chk_counters("t3");
    for (int i = 0; i < 5; i++) begin
      next_good(w);
      beat(w);
      if (i == 3) chk("t3_prelock", {31'd0, locked}, 32'd0);
    end
    chk("t3_relock", {31'd0, locked}, 32'd1);

    // 4: drop lock again, then a bad word in CHECK with match count 2
    for (int i = 0; i < 3; i++) begin
      next_good(w);
      beat(32'hDEAD_BEEF);
      want_wc += 32'd1;
      want_be += 32'($countones(32'hDEAD_BEEF ^ w));
    end
    want_ll = 8'd2;
    chk("t4_seek", {30'd0, state}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_good(w);
      beat(w);
    end
    chk("t4_check", {30'd0, state}, 32'd1);
    next_good(w);
    beat(w ^ 32'h0001_0000);
    chk("t4_bad", {30'd0, state}, 32'd0);
    chk_counters("t4");
    beat(32'h8000_0000);
    chk("t4_zero_seed", {30'd0, state}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      next_good(w);
      beat(w);
    end
    chk("t4_relock", {31'd0, locked}, 32'd1);

    // 5: random tvalid gaps and enable toggling while locked
    prev_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      v      = 1'($urandom_range(0, 1));
      en     = ($urandom_range(0, 3) != 0);
      w      = gen_word(gs);
      tvalid = v; tdata = w; enable = en;
      @(posedge clk); #1;
      if (v && prev_en) begin
        gs = w[30:0];
        want_wc += 32'd1;
      end
      prev_en = en;
      chk("t5_tready", {31'd0, tready}, {31'd0, en});
    end
    tvalid = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    chk_counters("t5");
    chk("t5_locked", {31'd0, locked}, 32'd1);
    clear = 1'b1;
    next_good(w);
    beat(w);
    clear = 1'b0;
    want_wc = 32'd0; want_be = 32'd0; want_ll = 8'd0;
    chk_counters("t5_clear");
    chk("t5_clear_state", {30'd0, state}, 32'd2);
    next_good(w);
    beat(w);
    want_wc = 32'd1;
    chk_counters("t5_after");

    // 6: reset mid-lock with tvalid high, then relock
    aresetn = 1'b0;
    tvalid  = 1'b1;
    tdata   = gen_word(gs);
    @(posedge clk); #1;
    want_wc = 32'd0;
    chk("t6_tready", {31'd0, tready}, 32'd0);
    chk("t6_state", {30'd0, state}, 32'd0);
    chk("t6_locked", {31'd0, locked}, 32'd0);
    chk_counters("t6");
    aresetn = 1'b1; tvalid = 1'b0;
    @(posedge clk); #1;
    chk("t6_tready_on", {31'd0, tready}, 32'd1);
    next_good(w);
    beat(w);
    chk("t6_check", {30'd0, state}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      next_good(w);
      beat(w);
      if (i == 4) chk("t6_prelock", {31'd0, locked}, 32'd0);
    end
    chk("t6_locked_again", {31'd0, locked}, 32'd1);
    chk("t6_state_locked", {30'd0, state}, 32'd2);
    tvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_prbs_checker.md
Name: axis_prbs_checker

Overview:
- Sits directly downstream of the receiver FIFO and consumes its AXI-Stream output of decrypted 32-bit words.
- Regenerates the PRBS-31 plaintext sequence that the transmit-side source produces, and self-synchronises to the incoming stream.
- Reports lock status, compared-word count, bit-error count and lock-loss count, giving an end-to-end check that decryption returns the original plaintext.

Parameters:
- C_DATA_WIDTH, 32, stream word width; only 32 is supported.
- C_LOCK_COUNT, 4, number of consecutive error-free words required in CHECK before the block declares lock.
- C_UNLOCK_COUNT, 3, number of consecutive errored words while LOCKED before lock is dropped.

Ports:
- i_aclk  in  1  clock.
- i_aresetn  in  1  reset; synchronous and active-low.
- i_enable  in  1  1 = consume and check words; 0 = hold tready low and freeze all state.
- i_clear  in  1  one-cycle pulse; zeroes the three counters and does not affect lock state.
- s_axis_tready  out  1  always equals i_enable (registered, so it applies from the next cycle).
- s_axis_tvalid  in  1  input word valid.
- s_axis_tdata  in  32  decrypted word; bit 31 is the first PRBS bit in time.
- o_locked  out  1  high while in LOCKED.
- o_state  out  2  0 = SEEK, 1 = CHECK, 2 = LOCKED.
- o_word_count  out  32  words compared while LOCKED; saturates at 0xFFFFFFFF.
- o_bit_errors  out  32  popcount of mismatched bits accumulated while LOCKED; saturating.
- o_lock_lost  out  8  number of LOCKED->SEEK transitions; saturating.

Behaviour:
- A beat is accepted when s_axis_tvalid && s_axis_tready. Nothing changes on cycles without an accepted beat, except i_clear and reset.
- Reset (i_aresetn = 0 at a clock edge):
  - s_axis_tready = 0, all counters = 0, state = SEEK, o_locked = 0, LFSR = 0.
  - Reset takes effect mid-frame and mid-lock equally; the beat presented in the reset cycle is not accepted.
- PRBS model: polynomial x^31 + x^28 + 1.
  - 31-bit state s. Next bit b = s[30] ^ s[27]; then s = {s[29:0], b}.
  - One word = 32 successive bits b, with the first bit in bit 31.
  - After a word d, the state equals d[30:0].
- SEEK, on an accepted beat d:
  - LFSR <= d[30:0]; match counter <= 0; go to CHECK.
  - If d[30:0] == 0, stay in SEEK (the all-zero state is illegal).
- CHECK, on an accepted beat:
  - Compare d with expected word E, the 32-bit advance of the LFSR.
  - On a match, LFSR advances and match counter increments. When the counter reaches C_LOCK_COUNT, go to LOCKED in the same cycle (o_locked high on the following cycle).
  - On a mismatch, go to SEEK; the mismatching word is not used as a seed.
  - Counters are not updated in CHECK.
- LOCKED, on an accepted beat:
  - LFSR always advances by the predicted sequence, never reseeding from data.
  - o_word_count += 1; o_bit_errors += popcount(d ^ E), saturating.
  - If d != E, increment the consecutive-error counter; otherwise clear it.
  - When the consecutive-error counter reaches C_UNLOCK_COUNT, go to SEEK, increment o_lock_lost, and clear the consecutive-error counter.
- Latency: counters and state reflect an accepted beat on the cycle after acceptance (registered outputs).
- i_clear in the same cycle as an accepted beat: the clear wins, so counters read 0 on the next cycle and that beat's increment is discarded. State still updates normally.
- i_enable low: tready drops on the next cycle. A beat accepted in the transition cycle is processed normally.
- Saturation: each counter holds at its all-ones value and never wraps.
- Popcount is 0..32. The saturating add uses a 33-bit intermediate.

Test Plan:
1. Reset, then i_enable = 1. Stream 10 correct PRBS words from seed 31'h7FFFFFFF, tvalid held high -> CHECK after beat 1, o_locked = 1 after beat 5; o_word_count = 5, o_bit_errors = 0 after beat 10.
2. Locked stream; flip bits 0 and 31 in one word -> o_bit_errors = 2, o_locked stays 1, o_lock_lost = 0.
3. Locked stream; replace 3 consecutive words with 0xDEADBEEF -> state = SEEK after the third, o_lock_lost = 1. A correct continuation relocks after a further 1 + 4 words.
4. In CHECK with match counter = 2, inject one bad word -> state = SEEK, no counter changes. Beat with d = 0x80000000 -> remains in SEEK.
5. Random tvalid gaps and i_enable toggling during a locked stream -> no false errors; o_word_count equals the exact number of accepted beats. Asserting i_clear together with a beat -> counters read 0 on the next cycle.
6. Assert i_aresetn low for one cycle mid-lock with tvalid high -> all outputs 0 and state = SEEK on the next cycle. Relock follows the scenario 1 timing.
